// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU front end: instruction geometry,
// field positions and the fetch-sequencer state encoding.
package cpu_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 21;

  localparam int Z_BIT    = 20;
  localparam int OP_MSB   = 19;
  localparam int OP_LSB   = 17;
  localparam int IMM_MSB  = 16;
  localparam int IMM_LSB  = 9;
  localparam int SRC1_MSB = 8;
  localparam int SRC1_LSB = 6;
  localparam int SRC2_MSB = 5;
  localparam int SRC2_LSB = 3;
  localparam int DST_MSB  = 2;
  localparam int DST_LSB  = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Host/control side of the instruction sequencer: program load, run control
// and the issued instruction stream with its status.
interface instr_sequencer_if #(
  parameter int AW = cpu_pkg::AW,
  parameter int IW = cpu_pkg::IW
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          start;
  logic [AW:0]   len;
  logic          step_mode;
  logic          step;
  logic          halt_req;
  logic [IW-1:0] instruction;
  logic          ld;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  modport master (
    output prog_we, prog_addr, prog_data, start, len, step_mode, step, halt_req,
    input  instruction, ld, pc, busy, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, len, step_mode, step, halt_req,
    output instruction, ld, pc, busy, done
  );
endinterface

// File: rtl/instr_sequencer_prog_ram.sv
// Program buffer: synchronous write, combinational read. Contents are
// deliberately not reset so a program survives a sequencer reset.
module prog_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 21
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);
  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_sequencer.sv
// Fetch sequencer: issues host-loaded instruction words to the CPU one per
// cycle (RUN) or per step pulse (STEP), with a one-cycle ld strobe per word.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int DEPTH = cpu_pkg::DEPTH,
  parameter int AW    = cpu_pkg::AW
) (
  input  logic              clk,
  input  logic              rst,
  instr_sequencer_if.slave  bus
);
  seq_state_t    state;
  logic [AW-1:0] pc;
  logic [AW:0]   len_q;
  logic [AW:0]   issued;
  logic [AW:0]   issued_nxt;
  logic [IW-1:0] instr_q;
  logic [IW-1:0] rd_data;
  logic          ld_q;
  logic          idle_like;
  logic          can_issue;
  logic          wr_en;

  always_comb begin
    idle_like  = (state == S_IDLE) || (state == S_DONE);
    issued_nxt = issued + 1'b1;
    can_issue  = !bus.halt_req &&
                 ((state == S_RUN) || ((state == S_STEP) && bus.step));
    wr_en      = bus.prog_we && idle_like;
  end

  prog_ram #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_prog_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (pc),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      len_q   <= '0;
      issued  <= '0;
      instr_q <= '0;
      ld_q    <= 1'b0;
    end else begin
      ld_q    <= 1'b0;
      instr_q <= '0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            pc     <= '0;
            issued <= '0;
            len_q  <= bus.len;
            if (bus.len == '0)     state <= S_DONE;
            else if (bus.step_mode) state <= S_STEP;
            else                    state <= S_RUN;
          end
        end
        S_RUN, S_STEP: begin
          if (bus.halt_req) begin
            state <= S_DONE;
          end else if (can_issue) begin
            instr_q <= rd_data;
            ld_q    <= 1'b1;
            pc      <= pc + 1'b1;
            issued  <= issued_nxt;
            // Termination uses the count, since pc wraps to 0 when len == DEPTH
            if (issued_nxt == len_q) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.instruction = instr_q;
  assign bus.ld          = ld_q;
  assign bus.pc          = pc;
  assign bus.busy        = (state == S_RUN) || (state == S_STEP);
  assign bus.done        = (state == S_DONE);
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: vector table for load/run/step plus
// hand sequences for halt, write protection, len boundaries and reset.
module tb_instr_sequencer;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [20:0] data;
    logic        start;
    logic [4:0]  len;
    logic        sm;
    logic        step;
    logic        halt;
    logic        ld;
    logic [20:0] instr;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t        tbl[$];
  logic [20:0] model [16];
  logic [20:0] w [4];

  function automatic vec_t mk(logic we, logic [3:0] addr, logic [20:0] data,
                              logic start, logic [4:0] len, logic sm,
                              logic step, logic halt, logic ld,
                              logic [20:0] instr, logic [3:0] pc,
                              logic busy, logic done);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.start = start; v.len = len;
    v.sm = sm; v.step = step; v.halt = halt; v.ld = ld; v.instr = instr;
    v.pc = pc; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 1'b0; bus.len = '0; bus.step_mode = 1'b0;
    bus.step = 1'b0; bus.halt_req = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic ld, input logic [20:0] instr,
                         input logic [3:0] pc, input logic busy, input logic done);
    chk({tag, ".ld"},    32'(bus.ld),          32'(ld));
    chk({tag, ".instr"}, 32'(bus.instruction), 32'(instr));
    chk({tag, ".pc"},    32'(bus.pc),          32'(pc));
    chk({tag, ".busy"},  32'(bus.busy),        32'(busy));
    chk({tag, ".done"},  32'(bus.done),        32'(done));
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [20:0] data);
    bus.prog_we = 1'b1; bus.prog_addr = addr; bus.prog_data = data;
    tick();
    bus.prog_we = 1'b0;
    model[addr] = data;
  endtask

  // Free-running execution of n words, checked against the bench's program copy.
  task automatic do_run(input int n, input string tag);
    bus.start = 1'b1; bus.len = 5'(n); bus.step_mode = 1'b0;
    tick();
    bus.start = 1'b0;
    if (n == 0) begin
      chk_out({tag, ".len0"}, 1'b0, '0, 4'd0, 1'b0, 1'b1);
      tick();
      chk({tag, ".len0_noissue"}, 32'(bus.ld), 32'd0);
    end else begin
      chk_out({tag, ".start"}, 1'b0, '0, 4'd0, 1'b1, 1'b0);
      for (int k = 0; k < n; k++) begin
        tick();
        chk($sformatf("%s.w%0d.ld", tag, k),    32'(bus.ld),          32'd1);
        chk($sformatf("%s.w%0d.instr", tag, k), 32'(bus.instruction), 32'(model[k]));
        chk($sformatf("%s.w%0d.pc", tag, k),    32'(bus.pc),          32'((k + 1) % 16));
      end
      chk({tag, ".end_done"}, 32'(bus.done), 32'd1);
      chk({tag, ".end_busy"}, 32'(bus.busy), 32'd0);
      tick();
      chk({tag, ".after_ld"}, 32'(bus.ld), 32'd0);
      chk({tag, ".after_instr"}, 32'(bus.instruction), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    vec_t v;
    n_cmp = 0;
    n_bad = 0;
    w[0] = 21'h0A0201; w[1] = 21'h020242; w[2] = 21'h040083; w[3] = 21'h1200C4;

    // Vector table: load, free run len=4, stepped run, halt out of STEP.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 4'(i), w[i], 0, 0, 0, 0, 0, 0, '0, 0, 0, 0));
    tbl.push_back(mk(0, 0, '0, 1, 4, 0, 0, 0, 0, '0, 0, 1, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, '0, 0, 0, 0, 0, 0, 1, w[k], 4'(k + 1), k != 3, k == 3));
    tbl.push_back(mk(0, 0, '0, 0, 0, 0, 0, 0, 0, '0, 4, 0, 1));
    tbl.push_back(mk(0, 0, '0, 1, 4, 1, 0, 0, 0, '0, 0, 1, 0));
    p = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3 || c == 7 || c == 8) begin
        tbl.push_back(mk(0, 0, '0, 0, 0, 0, 1, 0, 1, w[p], 4'(p + 1), 1, 0));
        p++;
      end else begin
        tbl.push_back(mk(0, 0, '0, 0, 0, 0, 0, 0, 0, '0, 4'(p), 1, 0));
      end
    end
    tbl.push_back(mk(0, 0, '0, 0, 0, 0, 1, 1, 0, '0, 3, 0, 1));

    set_idle();
    rst = 1'b0;
    #12;
    chk_out("reset", 1'b0, '0, 4'd0, 1'b0, 1'b0);
    #6 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) model[i] = '0;
    for (int i = 0; i < 4; i++) model[i] = w[i];

    for (int r = 0; r < tbl.size(); r++) begin
      v = tbl[r];
      bus.prog_we = v.we; bus.prog_addr = v.addr; bus.prog_data = v.data;
      bus.start = v.start; bus.len = v.len; bus.step_mode = v.sm;
      bus.step = v.step; bus.halt_req = v.halt;
      tick();
      chk_out($sformatf("vec%0d", r), v.ld, v.instr, v.pc, v.busy, v.done);
    end
    set_idle();

    // Halt in RUN the cycle word 1 is presented: no word 2, pc stops at 2.
    bus.start = 1'b1; bus.len = 5'd4;
    tick();
    bus.start = 1'b0;
    tick();
    chk("halt.w0", 32'(bus.instruction), 32'(w[0]));
    tick();
    chk("halt.w1", 32'(bus.instruction), 32'(w[1]));
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    chk_out("halt.edge", 1'b0, '0, 4'd2, 1'b0, 1'b1);
    tick();
    chk_out("halt.hold", 1'b0, '0, 4'd2, 1'b0, 1'b1);
    write_word(4'd2, 21'h155555);
    do_run(1, "len1");
    do_run(3, "chk_wr2");
    write_word(4'd2, w[2]);

    // Writes while busy are dropped.
    bus.start = 1'b1; bus.len = 5'd4;
    tick();
    bus.start = 1'b0;
    bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = 21'h1FFFFF;
    for (int i = 0; i < 20 && !bus.done; i++) tick();
    bus.prog_we = 1'b0;
    chk("busy_wr.reached_done", 32'(bus.done), 32'd1);
    do_run(1, "busy_wr.rerun");

    do_run(0, "len0_done");

    for (int i = 4; i < 16; i++) write_word(4'(i), 21'(i * 21'h01111 + 5));
    do_run(16, "len16");

    // Asynchronous reset between edges mid-run.
    bus.start = 1'b1; bus.len = 5'd16;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("pre_rst.ld", 32'(bus.ld), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, '0, 4'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    tick();
    chk_out("post_rst", 1'b0, '0, 4'd0, 1'b0, 1'b0);
    do_run(0, "len0_idle");
    do_run(16, "rerun_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
